// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_if
// Brief    : Raw key pads in, debounced level and event strobes out.
// Revision : 1.0
// ============================================================================
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Per-key synchroniser, tick-based debounce FSM and auto-repeat.
// Revision : 1.0
// ============================================================================
module key_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_CYCLES    = 48000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100
) (
  input  logic              CLK,
  input  logic              RST_N,
  key_debounce_if.slave     bus
);

  localparam int              c_tick_w    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);
  localparam logic [15:0]     c_db_last   = 16'(DEBOUNCE_TICKS - 1);
  localparam logic [15:0]     c_hold_last = 16'(HOLD_TICKS - 1);
  localparam logic [15:0]     c_rep_last  = 16'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick;

  // Pads are active-low; the synchroniser stores the pressed sense (1 = pressed).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~bus.KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == c_tick_last);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t      r_state;
    state_t      w_state_nx;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nx;
    logic [15:0] w_limit;
    logic        r_rep_phase;
    logic        w_rep_phase_nx;
    logic        r_level;
    logic        w_level_nx;
    logic        r_press;
    logic        w_press_nx;
    logic        r_release;
    logic        w_release_nx;
    logic        r_repeat;
    logic        w_repeat_nx;
    logic        w_key_s;

    assign w_key_s = r_sync2[k];
    assign w_limit = r_rep_phase ? c_rep_last : c_hold_last;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_rep_phase <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_state     <= w_state_nx;
        r_cnt       <= w_cnt_nx;
        r_rep_phase <= w_rep_phase_nx;
        r_level     <= w_level_nx;
        r_press     <= w_press_nx;
        r_release   <= w_release_nx;
        r_repeat    <= w_repeat_nx;
      end
    end

    // A key_s change always takes priority over a coincident tick.
    always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_rep_phase_nx = r_rep_phase;
      w_level_nx     = r_level;
      w_press_nx     = 1'b0;
      w_release_nx   = 1'b0;
      w_repeat_nx    = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_key_s) begin
            w_state_nx = PRESS_WAIT;
            w_cnt_nx   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_key_s) begin
            w_state_nx = IDLE;
          end else if (w_tick) begin
            if (r_cnt == c_db_last) begin
              w_state_nx     = PRESSED;
              w_level_nx     = 1'b1;
              w_press_nx     = 1'b1;
              w_cnt_nx       = '0;
              w_rep_phase_nx = 1'b0;
            end else begin
              w_cnt_nx = r_cnt + 16'd1;
            end
          end
        end
        PRESSED: begin
          if (!w_key_s) begin
            w_state_nx = RELEASE_WAIT;
            w_cnt_nx   = '0;
          end else if (w_tick) begin
            if (r_cnt == w_limit) begin
              w_repeat_nx    = 1'b1;
              w_cnt_nx       = '0;
              w_rep_phase_nx = 1'b1;
            end else begin
              w_cnt_nx = r_cnt + 16'd1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (w_key_s) begin
            w_state_nx = PRESSED;
            w_cnt_nx   = '0;
          end else if (w_tick) begin
            if (r_cnt == c_db_last) begin
              w_state_nx   = IDLE;
              w_level_nx   = 1'b0;
              w_release_nx = 1'b1;
              w_cnt_nx     = '0;
            end else begin
              w_cnt_nx = r_cnt + 16'd1;
            end
          end
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end

    assign bus.key_level[k]   = r_level;
    assign bus.key_press[k]   = r_press;
    assign bus.key_release[k] = r_release;
    assign bus.key_repeat[k]  = r_repeat;
  end

endmodule
`default_nettype wire
